// File: rtl/divclk_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : divclk_pkg
// Purpose : Shared FSM state encoding and default sizing for the clock
//           divider controller.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package divclk_pkg;

  localparam int         DEF_WIDTH = 8;
  localparam logic [7:0] DEF_CMP   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/divclk_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : divclk_cnt
// Purpose : Half-period counter. Wraps to 0 on reaching cmp_i and flags
//           that cycle as terminal count.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module divclk_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cmp_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Terminal count is a pure compare; cnt never exceeds cmp so no overflow.
  assign tc_o = (cnt_q == cmp_i);

  // Next count: clear dominates, otherwise wrap at the compare value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/divclk_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : divclk_ctrl
// Purpose : Programmable clock divider. New compare values arrive over a
//           valid/ready handshake and are applied only at a half-period
//           boundary so output_clock never glitches.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module divclk_ctrl
  import divclk_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_CMP = WIDTH'(DEF_CMP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_cmp,
  output logic             cfg_ready,
  output logic             output_clock,
  output logic             tick,
  output logic [WIDTH-1:0] cur_cmp,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             oclk_q, oclk_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  logic             w_run;
  logic             w_xfer;
  logic             w_cnt_tc;
  logic             w_tc;

  assign w_run  = (state_q != ST_IDLE);
  // Ready is decoded from the state register alone, never from inputs.
  assign cfg_ready = (state_q != ST_PEND);
  assign w_xfer = cfg_valid && cfg_ready;
  assign w_tc   = w_run && w_cnt_tc;

  divclk_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!w_run || !en),
    .en_i  (w_run && en),
    .cmp_i (cur_q),
    .tc_o  (w_cnt_tc)
  );

  // Next-state and next-output decode for the controller FSM.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    shadow_d = shadow_q;
    oclk_d   = oclk_q;
    tick_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        oclk_d = 1'b0;
        if (w_xfer) cur_d = cfg_cmp;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          // A value offered while stopping goes straight into effect.
          state_d = ST_IDLE;
          oclk_d  = 1'b0;
          if (w_xfer) cur_d = cfg_cmp;
        end else begin
          if (w_tc) begin
            oclk_d = !oclk_q;
            tick_d = !oclk_q;
          end
          // Boundary on this same edge still uses the old value.
          if (w_xfer) begin
            shadow_d = cfg_cmp;
            state_d  = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!en) begin
          // Never drop a pending ratio on disable.
          state_d = ST_IDLE;
          oclk_d  = 1'b0;
          cur_d   = shadow_q;
        end else if (w_tc) begin
          oclk_d  = !oclk_q;
          tick_d  = !oclk_q;
          cur_d   = shadow_q;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oclk_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= DEFAULT_CMP;
      shadow_q <= '0;
      oclk_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      shadow_q <= shadow_d;
      oclk_q   <= oclk_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign output_clock = oclk_q;
  assign tick         = tick_q;
  assign cur_cmp      = cur_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: doc/divclk_ctrl.md
# divclk_ctrl

Runtime-programmable clock-divider controller. Owns a WIDTH-bit half-period counter and a compare register, generates a divided `output_clock` plus a one-cycle `tick` on each rising edge, and accepts new divide ratios over a valid/ready handshake. New ratios are applied only at a half-period boundary so `output_clock` never produces a runt pulse. It sits between the register/config logic and downstream consumers of the slow clock enable, such as the 1 Hz timebase.

## Interface
- `WIDTH`, 8, width of counter and compare value
- `DEFAULT_CMP`, 8'hFF, compare value loaded at reset
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  run enable; level-sensitive
- `cfg_valid`  in  1  new compare value offered
- `cfg_cmp`  in  WIDTH  offered compare value
- `cfg_ready`  out  1  controller can accept a compare value
- `output_clock`  out  1  divided clock, registered
- `tick`  out  1  one-cycle pulse, high in the same cycle `output_clock` goes 0→1
- `cur_cmp`  out  WIDTH  compare value currently in effect
- `busy`  out  1  high in RUN or PEND

## Operation
- Single clock, one asynchronous active-low reset (`clk`, `rst_n`).
- Reset values:
  - state IDLE, `cnt` 0, `cur_cmp` = DEFAULT_CMP, shadow 0
  - `output_clock` 0, `tick` 0, `cfg_ready` 1, `busy` 0
- States:
  - IDLE: counter held at 0, `output_clock` 0. `en`=1 → RUN.
  - RUN: counting. Accepted config → PEND. `en`=0 → IDLE.
  - PEND: counting with a value waiting in the shadow register. Terminal count → RUN with the new value. `en`=0 → IDLE.
- Counter in RUN/PEND:
  - if `cnt` == `cur_cmp`: `cnt` ← 0 and `output_clock` toggles (terminal count)
  - else: `cnt` ← `cnt`+1
  - Half period = `cur_cmp`+1 cycles; full period = 2·(`cur_cmp`+1).
- `cur_cmp` = 0 gives `clk`/2. Maximum is 2^WIDTH−1. No overflow is possible because `cnt` never exceeds `cur_cmp`.
- Handshake:
  - A transfer occurs when `cfg_valid` && `cfg_ready` at an edge.
  - `cfg_ready` = (state != PEND).
  - Transfer in IDLE: `cur_cmp` ← `cfg_cmp` at that edge.
  - Transfer in RUN: shadow ← `cfg_cmp` and state → PEND. The value takes effect at the next terminal count after the transfer edge.
  - At that terminal count: `cur_cmp` ← shadow, `cnt` ← 0, `output_clock` toggles, state → RUN.
  - A transfer on the same edge as a terminal count does not affect that boundary; the value applies at the following one.
- Disable (`en`=0 sampled in RUN/PEND):
  - Next edge: state IDLE, `cnt` 0, `output_clock` 0, `tick` 0.
  - A pending shadow value is copied into `cur_cmp`, so a new ratio is never lost.
- `en` and a transfer on the same edge in IDLE: state → RUN with `cnt` 0 and `cur_cmp` ← `cfg_cmp`.
- `tick` = registered (terminal count && `output_clock`==0).
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and any pending value is discarded.

## Timing
- Edge at which `en`=1 is sampled in IDLE = edge E0 (state → RUN, `cnt` 0).
- First `output_clock` rise and `tick` at edge E0+`cur_cmp`+1. Falls are every `cur_cmp`+1 edges after that.
- Handshake latency:
  - `cfg_ready` drops the cycle after a RUN transfer.
  - `cfg_ready` rises the cycle after the applying terminal count.
  - Worst-case PEND duration is `cur_cmp`+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs except `cfg_ready`, which is decoded from the state register only.

## Structure
- Package `divclk_pkg` holds:
  - state enum (IDLE, RUN, PEND)
  - default WIDTH and DEFAULT_CMP constants
- Sub-module `divclk_cnt`: WIDTH-bit counter with clear, enable, `cmp` input and `tc` output. `divclk_ctrl` owns the FSM, the shadow/compare registers and the output registers.

## Test plan
- Reset with DEFAULT_CMP=2'b11, WIDTH=2, then `en`=1 → `output_clock` period 8 cycles, first rise 4 cycles after RUN entry, `tick` exactly once per period.
- In IDLE, transfer `cfg_cmp`=0, then `en`=1 → `output_clock` toggles every cycle and `tick` every 2 cycles.
- In RUN with `cur_cmp`=3, transfer `cfg_cmp`=1 at `cnt`=1:
  - `cfg_ready` is 0 until the terminal count
  - half-period 4 completes unchanged, then half-periods become 2 cycles
  - no pulse shorter than 2 cycles appears
- Transfer on the same edge as a terminal count → that half-period uses the old value; the new value applies at the next boundary.
- In PEND, deassert `en` → IDLE, `output_clock` 0, `cur_cmp` equals the shadow value, `cfg_ready` 1.
- Assert `rst_n`=0 mid-PEND → all outputs return to reset values asynchronously, `cur_cmp`=DEFAULT_CMP, and the pending value is discarded.
